// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
//
// Owns the HI/LO architectural registers. A mult/multu/div/divu issued from EX
// is evaluated at issue time into staging registers. busy is then held for a
// fixed latency, and the staged result is committed to HI/LO on the last
// cycle. mthi/mtlo write HI/LO directly while the unit is idle. flush cancels
// an in-flight op without a commit.
//
// Optional feature: define MD_MADD_EN to enable madd/maddu/msub/msubu
// (md_op 1xx). These accumulate the staged product into {HI,LO} at commit.
// Without MD_MADD_EN, 1xx codes are ignored and no accumulate adder exists.
//
// Parameters:
//   MULT_CYCLES  cycles from start to commit for multiply-class ops (1..255)
//   DIV_CYCLES   cycles from start to commit for div/divu (1..255)
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   EX holds a valid md op this cycle
//   md_op    in   000 mult, 001 multu, 010 div, 011 divu, 1xx madd family
//   A        in   rs operand (forwarded)
//   B        in   rt operand (forwarded)
//   mthi     in   write A into HI (idle only)
//   mtlo     in   write A into LO (idle only)
//   flush    in   cancel in-flight op, suppress start/mthi/mtlo this cycle
//   busy     out  op in flight (registered)
//   HI       out  HI register
//   LO       out  LO register

module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] s_hi_q, s_hi_d;
    logic [31:0] s_lo_q, s_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

`ifdef MD_MADD_EN
    // Remember whether the staged value is a product to accumulate, and its sign.
    logic        acc_q, acc_d;
    logic        sub_q, sub_d;
    logic [63:0] acc_result;
`endif

    // ------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------
    logic op_legal;
    logic op_is_div;
    logic op_signed;

`ifdef MD_MADD_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~md_op[2];
`endif
    assign op_is_div = ~md_op[2] & md_op[1];
    // Bit 0 selects the unsigned variant for every op class.
    assign op_signed = ~md_op[0];

    // ------------------------------------------------------------------
    // Multiplier: operands sign- or zero-extended to 64 bits so a single
    // unsigned 64x64 multiply yields the correct low 64 bits for both forms.
    // ------------------------------------------------------------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a   = {{32{op_signed & A[31]}}, A};
    assign mul_b   = {{32{op_signed & B[31]}}, B};
    assign product = mul_a * mul_b;

    // ------------------------------------------------------------------
    // Divider: done on magnitudes, then signs restored. Quotient truncates
    // toward zero; the remainder takes the dividend's sign. For
    // 0x80000000 / -1 the magnitude quotient is 0x80000000 and no negation
    // applies (both negative), which gives the required LO=0x80000000, HI=0.
    // ------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign a_neg = op_signed & A[31];
    assign b_neg = op_signed & B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;

    // b_mag == 0 is overridden below, so the divider result is don't-care then.
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);

    assign quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign remainder = a_neg ? (~r_mag + 32'd1) : r_mag;

    // Value staged at start: {HI, LO} to be committed.
    logic [31:0] stage_hi;
    logic [31:0] stage_lo;

    always_comb begin
        if (op_is_div) begin
            if (B == 32'd0) begin
                stage_hi = A;
                stage_lo = 32'hFFFF_FFFF;
            end else begin
                stage_hi = remainder;
                stage_lo = quotient;
            end
        end else begin
            stage_hi = product[63:32];
            stage_lo = product[31:0];
        end
    end

`ifdef MD_MADD_EN
    // Accumulation uses HI/LO as they stand at the commit edge, modulo 2^64.
    assign acc_result = sub_q ? ({hi_q, lo_q} - {s_hi_q, s_lo_q})
                              : ({hi_q, lo_q} + {s_hi_q, s_lo_q});
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_hi_d  = s_hi_q;
        s_lo_d  = s_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MD_MADD_EN
        acc_d   = acc_q;
        sub_d   = sub_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // flush suppresses start, mthi and mtlo alike.
                if (!flush) begin
                    if (start && op_legal) begin
                        s_hi_d  = stage_hi;
                        s_lo_d  = stage_lo;
                        cnt_d   = op_is_div ? DIV_LOAD : MULT_LOAD;
                        state_d = ST_RUN;
`ifdef MD_MADD_EN
                        acc_d   = md_op[2];
                        sub_d   = md_op[1];
`endif
                    end else if (mthi) begin
                        hi_d = A;
                    end else if (mtlo) begin
                        lo_d = A;
                    end
                end
            end

            ST_RUN: begin
                if (flush) begin
                    // Abort: HI/LO keep their pre-op values.
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd1) begin
`ifdef MD_MADD_EN
                    if (acc_q) begin
                        hi_d = acc_result[63:32];
                        lo_d = acc_result[31:0];
                    end else begin
                        hi_d = s_hi_q;
                        lo_d = s_lo_q;
                    end
`else
                    hi_d = s_hi_q;
                    lo_d = s_lo_q;
`endif
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            s_hi_q  <= 32'd0;
            s_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_hi_q  <= s_hi_d;
            s_lo_q  <= s_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

`ifdef MD_MADD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= 1'b0;
            sub_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end
`endif

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    md_sequencer #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .flush  (flush),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model of HI/LO.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference result {HI, LO} from the arithmetic rules.
    function automatic logic [63:0] model_md(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     prod;
        int              si;
        int              sj;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                si = a;
                sj = b;
                return {32'(si % sj), 32'(si / sj)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                prod = op[0] ? (ua * ub) : 64'(sa * sb);
                return op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
            end
        endcase
    endfunction

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy === 1'b1 && c < 300) begin
            tick;
            c++;
        end
        if (c >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still %b after 300 cycles, required 0", name, busy);
        end
    endtask

    // Issue one op, measure busy length, check HI/LO stable until commit.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        int          cycles;
        int          early;
        pre_hi = HI;
        pre_lo = LO;
        start  = 1'b1;
        md_op  = op;
        A      = a;
        B      = b;
        tick;
        start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        cycles = 0;
        early  = 0;
        while (busy === 1'b1 && cycles < 300) begin
            if (HI !== pre_hi || LO !== pre_lo) early++;
            tick;
            cycles++;
        end
        check32({name, " latency"}, 32'(cycles), 32'(cyc));
        check32({name, " early commits"}, 32'(early), 32'd0);
        check32({name, " HI"}, HI, exp_hi);
        check32({name, " LO"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [31:0] val);
        mthi = hi_en;
        mtlo = lo_en;
        A    = val;
        tick;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (hi_en) m_hi = val;
        else if (lo_en) m_lo = val;
    endtask

    logic [63:0] exp64;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    initial begin
        vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7, MC, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{3'd1, 32'hFFFF_FFFD, 32'd7, MC, 32'h0000_0006, 32'hFFFF_FFEB};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd100, 32'd7, DC, 32'd2, 32'd14};
        vecs[4] = '{3'd2, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF};
        vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000};
        vecs[6] = '{3'd3, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF};
        vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'd0};

        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'd0;
        A       = 32'd0;
        B       = 32'd0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        flush   = 1'b0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        #12;
        check32("reset busy", {31'd0, busy}, 32'd0);
        check32("reset HI", HI, 32'd0);
        check32("reset LO", LO, 32'd0);
        reset_n = 1'b1;
        tick;

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc,
                   vecs[i].hi, vecs[i].lo);
        end

        // Preload via mthi/mtlo.
        mt(1'b1, 1'b0, 32'h1234_5678);
        mt(1'b0, 1'b1, 32'h1234_5678);
        check32("preload HI", HI, 32'h1234_5678);
        check32("preload LO", LO, 32'h1234_5678);

        // Flush in the middle of a div.
        start = 1'b1;
        md_op = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        tick;
        start = 1'b0;
        repeat (3) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check32("flush mid busy", {31'd0, busy}, 32'd0);
        tick;
        check32("flush mid busy later", {31'd0, busy}, 32'd0);
        check32("flush mid HI", HI, 32'h1234_5678);
        check32("flush mid LO", LO, 32'h1234_5678);

        // Flush on the commit edge.
        start = 1'b1;
        md_op = 3'd3;
        A     = 32'd100;
        B     = 32'd7;
        tick;
        start = 1'b0;
        repeat (DC - 1) tick;
        check32("flush commit busy before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check32("flush commit busy", {31'd0, busy}, 32'd0);
        check32("flush commit HI", HI, 32'h1234_5678);
        check32("flush commit LO", LO, 32'h1234_5678);

        // mthi beats mtlo.
        mt(1'b1, 1'b1, 32'hAAAA_5555);
        check32("mthi+mtlo HI", HI, 32'hAAAA_5555);
        check32("mthi+mtlo LO", LO, 32'h1234_5678);

        // mthi during RUN is ignored.
        start = 1'b1;
        md_op = 3'd0;
        A     = 32'd3;
        B     = 32'd4;
        tick;
        start = 1'b0;
        mthi  = 1'b1;
        A     = 32'h0000_DEAD;
        tick;
        mthi  = 1'b0;
        wait_idle("mthi in run");
        check32("mthi in run HI", HI, 32'd0);
        check32("mthi in run LO", LO, 32'd12);

        // start + mthi in IDLE: start wins.
        start = 1'b1;
        mthi  = 1'b1;
        md_op = 3'd0;
        A     = 32'd2;
        B     = 32'd3;
        tick;
        start = 1'b0;
        mthi  = 1'b0;
        check32("start+mthi busy", {31'd0, busy}, 32'd1);
        wait_idle("start+mthi");
        check32("start+mthi HI", HI, 32'd0);
        check32("start+mthi LO", LO, 32'd6);

        // start with flush is suppressed.
        start = 1'b1;
        flush = 1'b1;
        md_op = 3'd3;
        A     = 32'd50;
        B     = 32'd3;
        tick;
        start = 1'b0;
        flush = 1'b0;
        check32("start+flush busy", {31'd0, busy}, 32'd0);
        check32("start+flush LO", LO, 32'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;

`ifndef MD_MADD_EN
        // 1xx codes are not ops in this build.
        start = 1'b1;
        md_op = 3'd4;
        A     = 32'd7;
        B     = 32'd9;
        tick;
        start = 1'b0;
        check32("illegal op busy", {31'd0, busy}, 32'd0);
        tick;
        check32("illegal op HI", HI, 32'd0);
        check32("illegal op LO", LO, 32'd6);
`else
        mt(1'b1, 1'b0, 32'd0);
        mt(1'b0, 1'b1, 32'd10);
        run_op("madd", 3'd4, 32'hFFFF_FFFE, 32'd3, MC, 32'd0, 32'd4);
        run_op("msubu", 3'd7, 32'd1, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

        // Randomized ops against the model.
        for (int i = 0; i < 30; i++) begin
`ifdef MD_MADD_EN
            r_op = 3'($urandom_range(0, 7));
`else
            r_op = 3'($urandom_range(0, 3));
`endif
            r_a = $urandom;
            r_b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 4) == 0) mt(1'b1, 1'b0, $urandom);
            if ($urandom_range(0, 4) == 0) mt(1'b0, 1'b1, $urandom);
            exp64 = model_md(r_op, r_a, r_b, m_hi, m_lo);
            run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b,
                   (r_op[2] == 1'b0 && r_op[1] == 1'b1) ? DC : MC,
                   exp64[63:32], exp64[31:0]);
        end

        // Asynchronous reset mid-mult.
        mt(1'b1, 1'b0, 32'hFFFF_0000);
        mt(1'b0, 1'b1, 32'h0000_FFFF);
        start = 1'b1;
        md_op = 3'd0;
        A     = 32'd5;
        B     = 32'd5;
        tick;
        start = 1'b0;
        tick;
        #2;
        reset_n = 1'b0;
        #1;
        check32("async reset busy", {31'd0, busy}, 32'd0);
        check32("async reset HI", HI, 32'd0);
        check32("async reset LO", LO, 32'd0);
        #2;
        reset_n = 1'b1;
        repeat (MC + 1) tick;
        check32("post reset busy", {31'd0, busy}, 32'd0);
        check32("post reset LO", LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline. Owns the HI/LO registers.
- Accepts mult/multu/div/divu issued from EX and holds `busy` for a fixed latency. The hazard unit stalls mfhi/mflo/md ops against `busy`.
- Commits HI/LO at completion and services mthi/mtlo. HI/LO feed the mfhi/mflo write-back path.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO commit for mult/multu (legal 1..255).
- DIV_CYCLES, 10, cycles from start to HI/LO commit for div/divu (legal 1..255).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  EX holds a valid md op this cycle
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 1xx see Optional Feature
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- mthi  in  1  write A into HI
- mtlo  in  1  write A into LO
- flush  in  1  cancel in-flight op (exception/eret)
- busy  out  1  op in flight
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, staging regs=0, busy=0, HI=0, LO=0. Asserting reset mid-op aborts the op; no commit.
- States and transitions:
  - IDLE: on start with a legal op and no flush, at the edge: latch A/B-derived result into staging {S_HI,S_LO}, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: counter decrements each edge. Edge where counter==1: HI<=S_HI, LO<=S_LO, go to IDLE.
- Latency: start sampled at edge 0; HI/LO new at edge N; busy=1 from after edge 0 until edge N (exactly N cycles).
- busy is a registered output: busy = (state==RUN). It is not combinational from start; the hazard unit handles same-cycle collisions.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=prod[63:32], LO=prod[31:0].
  - multu: unsigned 32x32 -> 64; same split.
  - div: LO=quotient, HI=remainder, truncating toward zero; remainder takes the sign of the dividend.
  - divu: unsigned; same assignment.
  - Division by zero (B==0), div or divu: S_HI=A, S_LO=32'hFFFFFFFF. Still takes DIV_CYCLES.
  - div 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthi/mtlo:
  - In IDLE: write A to HI (or LO) at the next edge.
  - In RUN: ignored.
- Simultaneous start/mthi/mtlo in IDLE: priority start > mthi > mtlo; only the winner acts.
- start while RUN: ignored. The hazard unit guarantees it does not occur.
- flush:
  - In RUN: go to IDLE at the next edge, no commit; HI/LO keep their pre-op values; busy=0 next cycle.
  - Same cycle as start: start is suppressed.
  - Same cycle as the commit edge (counter==1): flush wins, no commit.
  - flush also suppresses mthi/mtlo that cycle.
- Illegal md_op (1xx without feature): treated as no start; state unchanged.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: md_op 100 madd, 101 maddu, 110 msub, 111 msubu.
  - Use MULT_CYCLES.
  - At commit: {HI,LO} <= {HI,LO} ± product (signed for madd/msub, unsigned for maddu/msubu), modulo 2^64.
  - The product is staged at start. Accumulation uses HI/LO as they stand at the commit edge.
- Undefined: 1xx codes are illegal (no-op); no accumulate adder is synthesized.

Test Plan:
- mult A=32'hFFFFFFFD (-3), B=7 -> busy high exactly 5 cycles; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB at edge 5; unchanged before.
- multu A=32'hFFFFFFFD, B=7 -> HI=32'h00000006, LO=32'hFFFFFFEB.
- div A=-7, B=2 -> after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. divu A=100, B=7 -> LO=14, HI=2. div A=5, B=0 -> HI=5, LO=32'hFFFFFFFF.
- Preload HI=LO=32'h12345678 via mthi/mtlo, start div, assert flush at cycle 4 -> busy drops next cycle; HI=LO=32'h12345678. Repeat with flush on the commit edge -> same result.
- During RUN pulse mthi A=32'hDEAD -> ignored; HI shows the op result. In IDLE, start+mthi together -> op runs; HI not written with A.
- Assert reset_n=0 mid-mult asynchronously (between edges) -> busy, HI, LO = 0 immediately. With MD_MADD_EN: HI=0, LO=10, madd A=-2, B=3 -> HI=0, LO=4. msubu A=1, B=5 from HI=0, LO=4 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFF.
